ps2_key_decoder: RTL
====================

# ps2_key_decoder

Receives raw PS/2 keyboard traffic and turns it into the two 5-bit one-hot button vectors the game scene consumes (`player1_btns`, `player2_btns`). It sits directly upstream of the game scene, in the `clk_25m` domain. It synchronises the PS/2 lines, deframes 11-bit scan-code frames, tracks make/break/extended prefixes and maintains a held-key map per player. Each output vector presents at most one active bit, encoded UP=00001, DOWN=00010, LEFT=00100, RIGHT=01000, FIRE=10000.

## Interface
- `TIMEOUT_CYCLES`, default 2500: `clk_25m` cycles (100 µs) without a PS/2 falling edge before a partial frame is abandoned.
- `clk_25m` input 1: system clock, 25 MHz.
- `rst_n` input 1: asynchronous, active-low reset; clock is `clk_25m`.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `player1_btns` output 5: one-hot held-key vector for player 1; 0 = none.
- `player2_btns` output 5: one-hot held-key vector for player 2.
- `scan_valid` output 1: one-cycle pulse when a good frame completes.
- `scan_code` output 8: data byte of the last good frame; holds between pulses.
- `frame_err` output 1: one-cycle pulse on a parity, start-bit or stop-bit error, or on a timeout.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A falling edge is detected when the synchronised previous value is 1 and the current value is 0. All frame sampling happens on detected falling edges.
- **Receiver FSM:**
  - **IDLE:** on an edge, sample the start bit. 0 → DATA with bit count 0. 1 → `frame_err` and stay in IDLE.
  - **DATA:** 8 edges, shifting the data in LSB first. → PARITY.
  - **PARITY:** sample the parity bit and check odd parity over data+parity. → STOP.
  - **STOP:** sample the stop bit. If stop=1 and parity is good, the frame is good: pulse `scan_valid` and load `scan_code`. Otherwise pulse `frame_err`. → IDLE.
- **Timeout:** a 12-bit idle counter clears on every edge and increments otherwise. In any state other than IDLE, reaching `TIMEOUT_CYCLES` returns the FSM to IDLE and pulses `frame_err`. The counter saturates and does not wrap.
- **Prefix handling**, acting on good frames only:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other code is a key event: make if `brk`=0, break if `brk`=1. After a key event, `ext` and `brk` both clear.
  - A `frame_err` also clears `ext` and `brk`.
- **Key map:**
  - Player 1 (non-extended codes): W 0x1D = UP, S 0x1B = DOWN, A 0x1C = LEFT, D 0x23 = RIGHT, Space 0x29 = FIRE.
  - Player 2: extended 0x75 = UP, extended 0x72 = DOWN, extended 0x6B = LEFT, extended 0x74 = RIGHT, 0x5A = FIRE with `ext` ignored.
  - Unmapped codes, and mapped codes with the wrong `ext` value, change nothing.
  - A make sets the key's held bit; a break clears it. Repeated makes (typematic) are idempotent.
- **Output encode**, per player from the 5-bit held map:
  - Any direction held → the highest-priority direction only, priority UP > DOWN > LEFT > RIGHT.
  - Else FIRE held → 10000.
  - Else 00000.
  - The output is registered.

## Timing
- Reset values: `player1_btns`=0, `player2_btns`=0, `scan_valid`=0, `scan_code`=0x00, `frame_err`=0. Held maps, `ext`, `brk`, FSM=IDLE and all counters are also cleared.
- Edge-detect latency: 3 `clk_25m` cycles from the `ps2_clk` pin fall to the internal edge strobe.
- Cycle N = edge strobe sampling the stop bit. `scan_valid` / `scan_code` / `frame_err` are valid at N+1. The held map updates at N+2. The `btns` outputs change at N+3.
- The `scan_valid` and `frame_err` pulses are exactly 1 cycle and never assert together.
- Reset mid-frame discards the partial frame and all held keys. No output pulse is produced after reset release until a new complete frame arrives.
- Both players may change in the same cycle only if a single event maps to both; no mapping does that, so at most one vector changes per key event.

## Test plan
- **Make W:** frame 0x1D with parity 1 and stop 1 → `scan_valid` pulse, `scan_code`=0x1D, `player1_btns`=00001 at N+3, `player2_btns`=0.
- **Break W:** F0, 1D → `player1_btns` returns to 00000. Sending 0x1D twice before the break leaves the value at 00001.
- **Extended:** E0 75 → `player2_btns`=00001. Then E0 F0 75 → 00000. A non-extended 0x75 → no change.
- **Priority and fire:** hold Space then A → `player1_btns` goes 10000, then 00100. Release A → 10000. Release Space → 00000.
- **Errors:** a frame with bad parity (0x1D with parity 0) → `frame_err` pulse, no `scan_valid`, `btns` unchanged. A stop bit of 0 gives the same result. F0 followed by a bad frame, then 0x1D → treated as a make (`brk` was cleared).
- **Timeout and reset:** stop `ps2_clk` after 4 data bits for 2500 cycles → `frame_err`, then a fresh full frame decodes correctly. Assert `rst_n` while keys are held → all outputs become 0 immediately.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver mapping scan codes to per-player one-hot button vectors.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] player1_btns,
    output logic [4:0] player2_btns,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam logic [11:0] TIMEOUT_LIM = 12'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [2:0]  clk_sh;
    logic [1:0]  dat_sh;
    logic        fall_stb;
    logic        dat_q;
    logic [11:0] idle_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_ok;
    logic        good_frame;
    logic        bad_frame;
    logic        ext;
    logic        brk;
    logic [4:0]  held1;
    logic [4:0]  held2;
    logic [4:0]  key_p1;
    logic [4:0]  key_p2;

    // Strobe is registered so data sampled alongside it stays aligned with the synchronised clock.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            clk_sh   <= 3'b111;
            dat_sh   <= 2'b11;
            fall_stb <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_sh   <= {clk_sh[1:0], ps2_clk};
            dat_sh   <= {dat_sh[0], ps2_data};
            fall_stb <= clk_sh[2] & ~clk_sh[1];
            dat_q    <= dat_sh[1];
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 12'd0;
        end else if (fall_stb) begin
            idle_cnt <= 12'd0;
        end else if (idle_cnt != 12'hFFF) begin
            idle_cnt <= idle_cnt + 12'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (state != ST_IDLE && idle_cnt >= TIMEOUT_LIM) begin
            state_nxt = ST_IDLE;
            bad_frame = 1'b1;
        end else if (fall_stb) begin
            case (state)
                ST_IDLE: begin
                    if (dat_q) begin
                        bad_frame = 1'b1;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    if (dat_q && par_ok) begin
                        good_frame = 1'b1;
                    end else begin
                        bad_frame = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_ok     <= 1'b0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= 8'd0;
        end else begin
            state      <= state_nxt;
            scan_valid <= good_frame;
            frame_err  <= bad_frame;
            if (good_frame) begin
                scan_code <= shreg;
            end
            if (fall_stb) begin
                case (state)
                    ST_IDLE: bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shreg   <= {dat_q, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_ok <= ^{shreg, dat_q};
                    default: ;
                endcase
            end
        end
    end

    // Extended-only codes are rejected when ext is clear, and vice versa; 0x5A ignores ext.
    always_comb begin
        key_p1 = 5'b00000;
        key_p2 = 5'b00000;
        case (scan_code)
            8'h1D: key_p1 = ext ? 5'b00000 : 5'b00001;
            8'h1B: key_p1 = ext ? 5'b00000 : 5'b00010;
            8'h1C: key_p1 = ext ? 5'b00000 : 5'b00100;
            8'h23: key_p1 = ext ? 5'b00000 : 5'b01000;
            8'h29: key_p1 = ext ? 5'b00000 : 5'b10000;
            8'h75: key_p2 = ext ? 5'b00001 : 5'b00000;
            8'h72: key_p2 = ext ? 5'b00010 : 5'b00000;
            8'h6B: key_p2 = ext ? 5'b00100 : 5'b00000;
            8'h74: key_p2 = ext ? 5'b01000 : 5'b00000;
            8'h5A: key_p2 = 5'b10000;
            default: ;
        endcase
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            held1 <= 5'b00000;
            held2 <= 5'b00000;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (scan_valid) begin
            case (scan_code)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                    held1 <= brk ? (held1 & ~key_p1) : (held1 | key_p1);
                    held2 <= brk ? (held2 & ~key_p2) : (held2 | key_p2);
                    ext   <= 1'b0;
                    brk   <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [4:0] encode_btns(input logic [4:0] held);
        if (held[0])      encode_btns = 5'b00001;
        else if (held[1]) encode_btns = 5'b00010;
        else if (held[2]) encode_btns = 5'b00100;
        else if (held[3]) encode_btns = 5'b01000;
        else if (held[4]) encode_btns = 5'b10000;
        else              encode_btns = 5'b00000;
    endfunction

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            player1_btns <= 5'b00000;
            player2_btns <= 5'b00000;
        end else begin
            player1_btns <= encode_btns(held1);
            player2_btns <= encode_btns(held2);
        end
    end

endmodule
